// File: rtl/syn_lb_byte_mstr.sv
// Byte-stream local-bus initiator: decodes framed read/write commands
// into single LB transactions and streams status/read data back.
module syn_lb_byte_mstr #(
    parameter int P_LB_DWIDTH  = 32,
    parameter int P_LB_AWIDTH  = 16,
    parameter int P_RD_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst_l,
    input  logic [7:0]             cmd_byte,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    output logic [7:0]             rsp_byte,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   lb_rd_en,
    output logic                   lb_wr_en,
    output logic [P_LB_AWIDTH-1:0] lb_addr,
    output logic [P_LB_DWIDTH-1:0] lb_wr_data,
    input  logic                   lb_rd_valid,
    input  logic [P_LB_DWIDTH-1:0] lb_rd_data,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int NDB = P_LB_DWIDTH / 8;
    localparam int NAB = (P_LB_AWIDTH + 7) / 8;

    localparam logic [7:0]  OP_WR   = 8'h57;
    localparam logic [7:0]  OP_RD   = 8'h52;
    localparam logic [7:0]  RSP_ACK = 8'h4B;
    localparam logic [7:0]  RSP_ERR = 8'hEE;
    localparam logic [7:0]  LAST_A  = 8'(NAB - 1);
    localparam logic [7:0]  LAST_D  = 8'(NDB - 1);
    localparam logic [7:0]  NDB_B   = 8'(NDB);
    localparam logic [15:0] TO_LAST = 16'(P_RD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_WR,
        S_RD,
        S_RD_WAIT,
        S_RSP
    } state_t;

    state_t                 state, state_nxt;
    logic                   is_wr, is_wr_nxt;
    logic [7:0]             bcnt, bcnt_nxt;
    logic [15:0]            tcnt, tcnt_nxt;
    logic [7:0]             rcnt, rcnt_nxt;
    logic [P_LB_DWIDTH-1:0] shreg, shreg_nxt;
    logic [P_LB_AWIDTH-1:0] addr_nxt;
    logic [P_LB_DWIDTH-1:0] wdata_nxt;
    logic                   terr_nxt;
    logic                   cmd_fire;
    logic                   rsp_fire;

    assign cmd_fire = cmd_valid & cmd_ready;
    assign rsp_fire = rsp_valid & rsp_ready;
    assign rsp_byte = shreg[P_LB_DWIDTH-1 -: 8];

    always_comb begin
        state_nxt = state;
        is_wr_nxt = is_wr;
        bcnt_nxt  = bcnt;
        tcnt_nxt  = tcnt;
        rcnt_nxt  = rcnt;
        shreg_nxt = shreg;
        addr_nxt  = lb_addr;
        wdata_nxt = lb_wr_data;
        terr_nxt  = timeout_err;
        unique case (state)
            S_IDLE: begin
                if (cmd_fire) begin
                    if (cmd_byte == OP_WR || cmd_byte == OP_RD) begin
                        is_wr_nxt = (cmd_byte == OP_WR);
                        bcnt_nxt  = '0;
                        state_nxt = S_ADDR;
                    end else begin
                        shreg_nxt = P_LB_DWIDTH'(RSP_ERR) << (P_LB_DWIDTH - 8);
                        rcnt_nxt  = 8'd1;
                        state_nxt = S_RSP;
                    end
                end
            end
            S_ADDR: begin
                if (cmd_fire) begin
                    // truncation drops address bits above the bus width
                    addr_nxt = P_LB_AWIDTH'({lb_addr, cmd_byte});
                    bcnt_nxt = bcnt + 8'd1;
                    if (bcnt == LAST_A) begin
                        bcnt_nxt  = '0;
                        state_nxt = is_wr ? S_WDATA : S_RD;
                    end
                end
            end
            S_WDATA: begin
                if (cmd_fire) begin
                    wdata_nxt = P_LB_DWIDTH'({lb_wr_data, cmd_byte});
                    bcnt_nxt  = bcnt + 8'd1;
                    if (bcnt == LAST_D) begin
                        bcnt_nxt  = '0;
                        state_nxt = S_WR;
                    end
                end
            end
            S_WR: begin
                shreg_nxt = P_LB_DWIDTH'(RSP_ACK) << (P_LB_DWIDTH - 8);
                rcnt_nxt  = 8'd1;
                state_nxt = S_RSP;
            end
            S_RD: begin
                tcnt_nxt  = '0;
                state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (lb_rd_valid) begin
                    shreg_nxt = lb_rd_data;
                    rcnt_nxt  = NDB_B;
                    state_nxt = S_RSP;
                end else if (tcnt == TO_LAST) begin
                    terr_nxt  = 1'b1;
                    shreg_nxt = P_LB_DWIDTH'(RSP_ERR) << (P_LB_DWIDTH - 8);
                    rcnt_nxt  = 8'd1;
                    state_nxt = S_RSP;
                end else begin
                    tcnt_nxt = tcnt + 16'd1;
                end
            end
            S_RSP: begin
                if (rsp_fire) begin
                    shreg_nxt = shreg << 8;
                    rcnt_nxt  = rcnt - 8'd1;
                    if (rcnt == 8'd1) begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state       <= S_IDLE;
            is_wr       <= 1'b0;
            bcnt        <= '0;
            tcnt        <= '0;
            rcnt        <= '0;
            shreg       <= '0;
            lb_addr     <= '0;
            lb_wr_data  <= '0;
            timeout_err <= 1'b0;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            lb_rd_en    <= 1'b0;
            lb_wr_en    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            is_wr       <= is_wr_nxt;
            bcnt        <= bcnt_nxt;
            tcnt        <= tcnt_nxt;
            rcnt        <= rcnt_nxt;
            shreg       <= shreg_nxt;
            lb_addr     <= addr_nxt;
            lb_wr_data  <= wdata_nxt;
            timeout_err <= terr_nxt;
            // strobes and flags are registered copies of the next state
            cmd_ready   <= (state_nxt == S_IDLE) || (state_nxt == S_ADDR) ||
                           (state_nxt == S_WDATA);
            rsp_valid   <= (state_nxt == S_RSP);
            lb_rd_en    <= (state_nxt == S_RD);
            lb_wr_en    <= (state_nxt == S_WR);
            busy        <= (state_nxt != S_IDLE);
        end
    end

endmodule

// File: tb/tb_syn_lb_byte_mstr.sv
// Randomized self-checking bench for syn_lb_byte_mstr against a
// transaction-level model of frames, responses and LB strobes.
`timescale 1ns/1ps
module tb_syn_lb_byte_mstr;

    logic        clk = 1'b0;
    logic        rst_l;
    logic [7:0]  cmd_byte;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  rsp_byte;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        lb_rd_en;
    logic        lb_wr_en;
    logic [15:0] lb_addr;
    logic [31:0] lb_wr_data;
    logic        lb_rd_valid;
    logic [31:0] lb_rd_data;
    logic        busy;
    logic        timeout_err;

    syn_lb_byte_mstr dut (
        .clk         (clk),
        .rst_l       (rst_l),
        .cmd_byte    (cmd_byte),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .rsp_byte    (rsp_byte),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .lb_rd_en    (lb_rd_en),
        .lb_wr_en    (lb_wr_en),
        .lb_addr     (lb_addr),
        .lb_wr_data  (lb_wr_data),
        .lb_rd_valid (lb_rd_valid),
        .lb_rd_data  (lb_rd_data),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          n_wr   = 0;
    int          n_rd   = 0;
    int          exp_wr = 0;
    int          exp_rd = 0;
    logic        exp_terr = 1'b0;
    logic [15:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [7:0]  fq[$];
    logic [7:0]  exp_q[$];

    always @(negedge clk) begin
        if (lb_wr_en) n_wr++;
        if (lb_rd_en) n_rd++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got hang, want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int g = 0;
        cmd_byte  = b;
        cmd_valid = 1'b1;
        while (!cmd_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!cmd_ready) chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        @(negedge clk);
    endtask

    task automatic send_frame(input bit gaps);
        for (int i = 0; i < fq.size(); i++) begin
            if (gaps && i > 0 && $urandom_range(0, 2) == 0) begin
                cmd_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            send_byte(fq[i]);
        end
        cmd_valid = 1'b0;
        fq.delete();
    endtask

    task automatic drain(input int mode);
        int   i = 0;
        int   g = 0;
        int   ph = 0;
        logic r;
        while (i < exp_q.size() && g < 400) begin
            g++;
            case (mode)
                0:       r = 1'b1;
                1:       r = ph[0];
                default: r = 1'($urandom_range(0, 1));
            endcase
            ph++;
            rsp_ready = r;
            if (rsp_valid) begin
                chk("rsp_byte", 32'(rsp_byte), 32'(exp_q[i]));
                if (r) i++;
            end
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        chk("rsp_count", i, exp_q.size());
        chk("rsp_done", 32'(rsp_valid), 32'd0);
        chk("busy_done", 32'(busy), 32'd0);
        chk("cmd_ready_done", 32'(cmd_ready), 32'd1);
        chk("hold_addr", 32'(lb_addr), 32'(m_addr));
        chk("hold_wdata", lb_wr_data, m_wdata);
        chk("terr", 32'(timeout_err), 32'(exp_terr));
        exp_q.delete();
    endtask

    task automatic do_write(input logic [15:0] a, input logic [31:0] d,
                            input bit gaps, input int mode);
        fq = {8'h57, a[15:8], a[7:0], d[31:24], d[23:16], d[15:8], d[7:0]};
        send_frame(gaps);
        chk("wr_en", 32'(lb_wr_en), 32'd1);
        chk("wr_addr", 32'(lb_addr), 32'(a));
        chk("wr_data", lb_wr_data, d);
        chk("wr_no_rsp_yet", 32'(rsp_valid), 32'd0);
        exp_wr++;
        m_addr  = a;
        m_wdata = d;
        @(negedge clk);
        chk("wr_en_pulse", 32'(lb_wr_en), 32'd0);
        chk("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        exp_q = {8'h4B};
        drain(mode);
    endtask

    // n = cycles after lb_rd_en the slave answers; 0 means never
    task automatic do_read(input logic [15:0] a, input logic [31:0] d,
                           input int n, input bit spur, input int mode,
                           input bit gaps);
        int   lim;
        logic early = 1'b0;
        logic tprev = 1'b0;
        logic told;
        fq = {8'h52, a[15:8], a[7:0]};
        send_frame(gaps);
        chk("rd_en", 32'(lb_rd_en), 32'd1);
        chk("rd_addr", 32'(lb_addr), 32'(a));
        exp_rd++;
        m_addr = a;
        told = exp_terr;
        if (spur) begin
            lb_rd_valid = 1'b1;
            lb_rd_data  = ~d;
        end
        lim = (n == 0) ? 256 : n + 1;
        for (int k = 1; k <= lim; k++) begin
            @(negedge clk);
            if (k == 1) chk("rd_en_pulse", 32'(lb_rd_en), 32'd0);
            if (k < lim && rsp_valid) early = 1'b1;
            if (k == lim - 1) tprev = timeout_err;
            lb_rd_valid = (n != 0 && k == n);
            lb_rd_data  = (n != 0 && k == n) ? d : $urandom;
        end
        chk("rd_early_rsp", 32'(early), 32'd0);
        chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        if (n == 0) begin
            chk("terr_before", 32'(tprev), 32'(told));
            chk("terr_rise", 32'(timeout_err), 32'd1);
            exp_terr = 1'b1;
            exp_q = {8'hEE};
        end else begin
            for (int i = 0; i < 4; i++)
                exp_q.push_back(8'(d >> (8 * (3 - i))));
        end
        drain(mode);
        if (n == 0) begin
            lb_rd_valid = 1'b1;
            lb_rd_data  = d;
            @(negedge clk);
            lb_rd_valid = 1'b0;
            @(negedge clk);
            chk("late_valid_ignored", 32'(rsp_valid | busy), 32'd0);
        end
    endtask

    task automatic do_illegal(input logic [7:0] op, input int mode);
        fq = {op};
        send_frame(1'b0);
        chk("ill_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("ill_no_strobe", 32'(lb_rd_en | lb_wr_en), 32'd0);
        exp_q = {8'hEE};
        drain(mode);
    endtask

    initial begin
        int          sel;
        logic [7:0]  op;
        rst_l       = 1'b0;
        cmd_byte    = '0;
        cmd_valid   = 1'b0;
        rsp_ready   = 1'b0;
        lb_rd_valid = 1'b0;
        lb_rd_data  = '0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_outs", 32'({rsp_valid, lb_rd_en, lb_wr_en, busy,
                             timeout_err}), 32'd0);
        chk("rst_rsp_byte", 32'(rsp_byte), 32'd0);
        chk("rst_addr", 32'(lb_addr), 32'd0);
        chk("rst_wdata", lb_wr_data, 32'd0);
        rst_l = 1'b1;
        @(negedge clk);
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        do_write(16'h1234, 32'hDEADBEEF, 1'b0, 0);
        do_read(16'h0010, 32'hCAFEF00D, 3, 1'b0, 0, 1'b0);
        do_read(16'h0010, 32'hCAFEF00D, 3, 1'b0, 1, 1'b0);
        do_read(16'h0ABC, 32'h13572468, 0, 1'b0, 0, 1'b0);
        do_write(16'h0BAD, 32'h0F1E2D3C, 1'b0, 0);
        do_illegal(8'h41, 0);
        do_read(16'h4321, 32'h89ABCDEF, 2, 1'b0, 0, 1'b0);

        lb_rd_valid = 1'b1;
        lb_rd_data  = 32'h55AA55AA;
        repeat (2) @(negedge clk);
        lb_rd_valid = 1'b0;
        chk("idle_valid_ignored", 32'(rsp_valid | busy), 32'd0);
        do_read(16'h7777, 32'h01020304, 4, 1'b1, 0, 1'b0);
        do_read(16'h7778, 32'hA5A5C3C3, 1, 1'b1, 2, 1'b0);

        fq = {8'h52, 8'h00};
        send_frame(1'b0);
        rst_l = 1'b0;
        @(negedge clk);
        exp_terr = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("mid_rst_outs", 32'({rsp_valid, lb_rd_en, lb_wr_en, busy,
                                 timeout_err}), 32'd0);
        chk("mid_rst_addr", 32'(lb_addr), 32'd0);
        chk("mid_rst_wdata", lb_wr_data, 32'd0);
        rst_l = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
        do_read(16'h2468, 32'hFEEDFACE, 2, 1'b0, 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4) begin
                do_write(16'($urandom), $urandom, 1'($urandom_range(0, 1)), 2);
            end else if (sel < 8) begin
                do_read(16'($urandom), $urandom, $urandom_range(1, 6),
                        1'($urandom_range(0, 1)), 2, 1'($urandom_range(0, 1)));
            end else if (sel == 8) begin
                do begin
                    op = 8'($urandom);
                end while (op == 8'h57 || op == 8'h52);
                do_illegal(op, 2);
            end else begin
                do_read(16'($urandom), $urandom, 0, 1'b0, 2, 1'b0);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        chk("wr_strobes", n_wr, exp_wr);
        chk("rd_strobes", n_rd, exp_rd);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
